// File: rtl/lr_stub_mac_accumulator.sv
// Per-track multiply-accumulate for the LR track fit: registered a*b product stage,
// then sigma(ab), sigma(a) and stub count per track, with one result word per track.
module lr_stub_mac_accumulator #(
  parameter int unsigned A_WIDTH    = 18,
  parameter int unsigned B_WIDTH    = 15,
  parameter int unsigned P_WIDTH    = 33,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned SUMA_WIDTH = 23,
  parameter int unsigned CNT_WIDTH  = 5,
  parameter int unsigned MAX_STUBS  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_WIDTH-1:0]    in_a,
  input  logic [B_WIDTH-1:0]    in_b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum_ab,
  output logic [SUMA_WIDTH-1:0] out_sum_a,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf
);

  logic [P_WIDTH-1:0]    r_s1_p;
  logic [A_WIDTH-1:0]    r_s1_a;
  logic                  r_s1_last;
  logic                  r_s1_valid;

  logic [ACC_WIDTH-1:0]  r_acc_ab;
  logic [SUMA_WIDTH-1:0] r_acc_a;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_ovf;

  logic                  r_out_valid;
  logic [ACC_WIDTH-1:0]  r_out_sum_ab;
  logic [SUMA_WIDTH-1:0] r_out_sum_a;
  logic [CNT_WIDTH-1:0]  r_out_count;
  logic                  r_out_ovf;

  logic                  w_stall;
  logic                  w_accept;
  logic                  w_s2_fire;
  logic                  w_take;
  logic [P_WIDTH-1:0]    w_a_ext;
  logic [P_WIDTH-1:0]    w_b_ext;
  logic [P_WIDTH-1:0]    w_product;
  logic [ACC_WIDTH-1:0]  w_p_ext;
  logic [SUMA_WIDTH-1:0] w_a_sum_ext;
  logic [ACC_WIDTH-1:0]  w_acc_ab_nxt;
  logic [SUMA_WIDTH-1:0] w_acc_a_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  w_ovf_nxt;

  // Only a completed track waiting on a full output register can block the pipe
  assign w_stall   = r_s1_valid & r_s1_last & r_out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_accept  = in_valid & in_ready;
  assign w_s2_fire = r_s1_valid & ~w_stall;

  // b is zero-extended so the product is a signed*unsigned value, exact in P_WIDTH
  assign w_a_ext   = {{(P_WIDTH-A_WIDTH){in_a[A_WIDTH-1]}}, in_a};
  assign w_b_ext   = {{(P_WIDTH-B_WIDTH){1'b0}}, in_b};
  assign w_product = $signed(w_a_ext) * $signed(w_b_ext);

  assign w_p_ext     = {{(ACC_WIDTH-P_WIDTH){r_s1_p[P_WIDTH-1]}}, r_s1_p};
  assign w_a_sum_ext = {{(SUMA_WIDTH-A_WIDTH){r_s1_a[A_WIDTH-1]}}, r_s1_a};
  assign w_take      = (r_cnt < CNT_WIDTH'(MAX_STUBS));

  always_comb begin
    w_acc_ab_nxt = r_acc_ab;
    w_acc_a_nxt  = r_acc_a;
    w_cnt_nxt    = r_cnt;
    w_ovf_nxt    = r_ovf;
    if (w_take) begin
      w_acc_ab_nxt = r_acc_ab + w_p_ext;
      w_acc_a_nxt  = r_acc_a + w_a_sum_ext;
      w_cnt_nxt    = r_cnt + CNT_WIDTH'(1);
    end else begin
      w_ovf_nxt    = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_p     <= '0;
      r_s1_a     <= '0;
      r_s1_last  <= 1'b0;
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_p     <= w_product;
      r_s1_a     <= in_a;
      r_s1_last  <= in_last;
      r_s1_valid <= 1'b1;
    end else if (!w_stall) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc_ab <= '0;
      r_acc_a  <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else if (w_s2_fire) begin
      if (r_s1_last) begin
        r_acc_ab <= '0;
        r_acc_a  <= '0;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        r_acc_ab <= w_acc_ab_nxt;
        r_acc_a  <= w_acc_a_nxt;
        r_cnt    <= w_cnt_nxt;
        r_ovf    <= w_ovf_nxt;
      end
    end
  end

  // A new result may replace one being handed off in the same cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_sum_ab <= '0;
      r_out_sum_a  <= '0;
      r_out_count  <= '0;
      r_out_ovf    <= 1'b0;
    end else if (w_s2_fire && r_s1_last) begin
      r_out_valid  <= 1'b1;
      r_out_sum_ab <= w_acc_ab_nxt;
      r_out_sum_a  <= w_acc_a_nxt;
      r_out_count  <= w_cnt_nxt;
      r_out_ovf    <= w_ovf_nxt;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sum_ab = r_out_sum_ab;
  assign out_sum_a  = r_out_sum_a;
  assign out_count  = r_out_count;
  assign out_ovf    = r_out_ovf;

endmodule

// File: tb/tb_lr_stub_mac_accumulator.sv
// Directed bench for lr_stub_mac_accumulator: hand-computed track results, latency,
// overflow, back-pressure and mid-track reset.
module tb_lr_stub_mac_accumulator;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [14:0] in_b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_sum_ab;
  logic [22:0] out_sum_a;
  logic [4:0]  out_count;
  logic        out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  lr_stub_mac_accumulator #(
    .A_WIDTH(18), .B_WIDTH(15), .P_WIDTH(33), .ACC_WIDTH(40),
    .SUMA_WIDTH(23), .CNT_WIDTH(5), .MAX_STUBS(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum_ab(out_sum_ab), .out_sum_a(out_sum_a),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input longint eab, input int ea,
                         input int ecnt, input bit eovf);
    logic [39:0] tab;
    logic [22:0] ta;
    tab = 40'(eab);
    ta  = 23'(ea);
    chk({tag, "_valid"},  {63'b0, out_valid}, 64'd1);
    chk({tag, "_sum_ab"}, {24'b0, out_sum_ab}, {24'b0, tab});
    chk({tag, "_sum_a"},  {41'b0, out_sum_a},  {41'b0, ta});
    chk({tag, "_count"},  {59'b0, out_count},  64'(ecnt));
    chk({tag, "_ovf"},    {63'b0, out_ovf},    {63'b0, eovf});
  endtask

  task automatic beat(input int a, input int b, input bit last);
    in_valid = 1'b1;
    in_a     = 18'(a);
    in_b     = 15'(b);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    in_valid  = 1'b1;
    in_a      = 18'd5;
    in_b      = 15'd5;
    in_last   = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_hold_valid", {63'b0, out_valid}, 64'd0);
    in_valid = 1'b0;
    ap_rst_n = 1'b1;
    chk("rst_valid",  {63'b0, out_valid},  64'd0);
    chk("rst_sum_ab", {24'b0, out_sum_ab}, 64'd0);
    chk("rst_sum_a",  {41'b0, out_sum_a},  64'd0);
    chk("rst_count",  {59'b0, out_count},  64'd0);
    chk("rst_ovf",    {63'b0, out_ovf},    64'd0);
    chk("rst_ready",  {63'b0, in_ready},   64'd1);
    tick();
    chk("rst_no_spurious", {63'b0, out_valid}, 64'd0);

    // Three-stub track with the most negative a times the largest b
    out_ready = 1'b1;
    beat(-3, 5, 0);
    beat(100, 2, 0);
    beat(-131072, 32767, 1);
    chk("t1_latency", {63'b0, out_valid}, 64'd0);
    tick();
    chk_res("t1", -64'sd4294836039, -130975, 3, 1'b0);
    tick();
    chk("t1_drain", {63'b0, out_valid}, 64'd0);

    // Back-to-back single-stub tracks
    beat(1, 1, 1);
    chk("s_latency", {63'b0, out_valid}, 64'd0);
    beat(2, 3, 1);
    chk_res("s1", 1, 1, 1, 1'b0);
    tick();
    chk_res("s2", 6, 2, 1, 1'b0);
    tick();
    chk("s_drain", {63'b0, out_valid}, 64'd0);

    // 18 stubs: only the first 16 are summed, ovf flagged
    for (int i = 0; i < 17; i++) beat(1, 1, 0);
    beat(1, 1, 1);
    tick();
    chk_res("ovf", 16, 16, 16, 1'b1);
    beat(2, 2, 1);
    tick();
    chk_res("post_ovf", 4, 2, 1, 1'b0);
    tick();

    // Back-pressure with two back-to-back tracks
    out_ready = 1'b0;
    beat(1, 2, 0);
    beat(3, 4, 1);
    beat(-2, 7, 0);
    beat(10, 1, 1);
    chk_res("bp_a", 14, 4, 2, 1'b0);
    chk("bp_stall_ready", {63'b0, in_ready}, 64'd0);
    tick();
    tick();
    chk_res("bp_a_hold", 14, 4, 2, 1'b0);
    chk("bp_stall_ready2", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_res("bp_b", -4, 8, 2, 1'b0);
    chk("bp_ready_back", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_drain", {63'b0, out_valid}, 64'd0);

    // Reset mid-track discards partial sums
    beat(7, 7, 0);
    beat(8, 8, 0);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    tick();
    chk("mrst_valid", {63'b0, out_valid}, 64'd0);
    beat(5, 4, 1);
    chk("mrst_latency", {63'b0, out_valid}, 64'd0);
    tick();
    chk_res("mrst", 20, 5, 1, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
